decoder_3to8_seq: RTL
=====================

DECODER_3TO8_SEQ -- requirements
Module: decoder_3to8_seq

Interface
REQ-001 SHALL have parameter: HOLD_CYCLES, 4, cycles each one-hot code is held on out (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: en  input  1  block enable, active high.
REQ-005 SHALL have port: in_valid  input  1  in_code is offered this cycle.
REQ-006 SHALL have port: in_code  input  3  binary index to decode.
REQ-007 SHALL have port: in_ready  output  1  block can accept a code this cycle.
REQ-008 SHALL have port: out  output  8  one-hot decoded value, all-zero when not holding.
REQ-009 SHALL have port: out_valid  output  1  high while out carries a code.
REQ-010 SHALL have port: done  output  1  high in the last hold cycle of each code.

Function
REQ-011 SHALL implement FSM states IDLE, HOLD, GAP, plus a 4-bit down-counter cnt and a one-entry pending register (pend_valid, pend_code).
REQ-012 SHALL drive in_ready = en & ~pend_valid, combinationally from registers and en only, in every state.
REQ-013 SHALL define accept = in_valid & in_ready; in_code is sampled only on accept.
REQ-014 IDLE: on accept, SHALL enter HOLD next cycle with out = 1<<in_code and cnt = HOLD_CYCLES-1; otherwise SHALL remain in IDLE.
REQ-015 HOLD: SHALL decrement cnt each cycle; when cnt==0, SHALL go to GAP next cycle.
REQ-016 HOLD: an accept SHALL load pend_code/pend_valid; out SHALL remain unchanged.
REQ-017 GAP: SHALL last exactly one cycle with out = 0 and out_valid = 0.
REQ-018 GAP exit priority: pend_valid -> HOLD with pend_code, pend_valid cleared; else accept -> HOLD with in_code; else IDLE.
REQ-019 out_valid SHALL equal (state==HOLD); out SHALL be exactly one-hot in HOLD and all-zero otherwise.
REQ-020 done SHALL equal (state==HOLD) & (cnt==0) & en; one pulse per code.
REQ-021 First-accept to out latency SHALL be 1 cycle; each code SHALL occupy exactly HOLD_CYCLES cycles; back-to-back codes SHALL be separated by exactly one GAP cycle.
REQ-022 HOLD_CYCLES=1: HOLD SHALL last one cycle with done high in that cycle.
REQ-023 Accept in the final HOLD cycle SHALL be stored as pending and issued after the GAP cycle.
REQ-024 en low in any state SHALL force IDLE next cycle: out=0, out_valid=0, cnt=0, pend_valid=0; the interrupted code SHALL produce no done.
REQ-025 in_code values are all legal (0..7); no error condition exists.

Reset
REQ-026 rst_n low SHALL immediately and asynchronously set state=IDLE, cnt=0, pend_valid=0, pend_code=0, out=8'h00, out_valid=0, done=0.
REQ-027 in_ready during reset SHALL equal en (pending empty).
REQ-028 Reset asserted mid-HOLD SHALL discard the current and pending codes; no done SHALL be produced for them.
REQ-029 After rst_n rises, the first accept SHALL be honoured on the first rising clk edge.

Verification
REQ-030 Single code: en=1, HOLD_CYCLES=4, in_code=5 accepted at cycle 0 -> out=8'h20, out_valid=1 cycles 1-4, done=1 cycle 4, out=0 cycle 5 (GAP), IDLE cycle 6.
REQ-031 Back-to-back: codes 0 then 7 offered continuously -> 8'h01 cycles 1-4, GAP cycle 5, 8'h80 cycles 6-9; in_ready=0 while pending is full.
REQ-032 Pending in last cycle: code 2 accepted at cycle 0, code 3 accepted at cycle 4 -> 8'h04 cycles 1-4, 0 cycle 5, 8'h08 cycles 6-9.
REQ-033 Enable drop: code 6 accepted, en=0 at cycle 2 -> out=0, out_valid=0 from cycle 3, no done, in_ready=0 while en=0.
REQ-034 Async reset: rst_n pulsed low mid-HOLD between clock edges -> out=0 and out_valid=0 immediately, pending cleared, next accept decoded normally.
REQ-035 HOLD_CYCLES=1 sweep of codes 0..7 -> out equals 1<<code for one cycle each with done high, GAP between codes, one-hot checked every cycle.

Source files
------------

// File: rtl/decoder_3to8_seq.sv
// rtl/decoder_3to8_seq.sv - sequenced 3-to-8 decoder, holds each one-hot code HOLD_CYCLES cycles
// One pending slot lets the next code be queued while the current one is held.
`timescale 1ns/1ps
module decoder_3to8_seq #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] code_q, code_d;
  logic       pend_valid_q, pend_valid_d;
  logic [2:0] pend_code_q, pend_code_d;
  logic       accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      code_q       <= 3'd0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
    end
  end

  // in_ready depends only on registers and en, so accept never loops through out
  assign in_ready = en & ~pend_valid_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    if (!en) begin
      state_d      = IDLE;
      cnt_d        = 4'd0;
      pend_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = HOLD;
            code_d  = in_code;
            cnt_d   = CNT_LOAD;
          end
        end
        HOLD: begin
          if (accept) begin
            pend_valid_d = 1'b1;
            pend_code_d  = in_code;
          end
          if (cnt_q == 4'd0) begin
            state_d = GAP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        GAP: begin
          // a queued code always wins; accept cannot fire while the slot is full
          if (pend_valid_q) begin
            state_d      = HOLD;
            code_d       = pend_code_q;
            cnt_d        = CNT_LOAD;
            pend_valid_d = 1'b0;
          end else if (accept) begin
            state_d = HOLD;
            code_d  = in_code;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q == HOLD);
    out       = out_valid ? (8'h01 << code_q) : 8'h00;
    done      = out_valid & (cnt_q == 4'd0) & en;
  end

endmodule
